// File: rtl/prod_accumulator_if.sv
// Product-in / sum-out handshake bundle for prod_accumulator.
interface prod_accumulator_if #(
  parameter int PW    = 8,
  parameter int ACC_W = 12
);
  logic             prod_valid;
  logic             prod_ready;
  logic [PW-1:0]    prod_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic             sum_ovf;
  logic [7:0]       sum_cnt;

  modport master (
    output prod_valid,
    output prod_data,
    output sum_ready,
    input  prod_ready,
    input  sum_valid,
    input  sum_data,
    input  sum_ovf,
    input  sum_cnt
  );

  modport slave (
    input  prod_valid,
    input  prod_data,
    input  sum_ready,
    output prod_ready,
    output sum_valid,
    output sum_data,
    output sum_ovf,
    output sum_cnt
  );
endinterface

// File: rtl/prod_accumulator.sv
// Saturating dot-product accumulator: sums L consecutive products,
// then holds the result on a registered valid/ready port.
module prod_accumulator #(
  parameter int PW    = 8,
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [LEN_W-1:0] cfg_len,
  prod_accumulator_if.slave bus
);
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             prod_ready_q;
  logic             sum_valid_q;
  logic [ACC_W-1:0] sum_data_q;
  logic             sum_ovf_q;
  logic [7:0]       sum_cnt_q;
  logic [ACC_W:0]   wide;
  logic             last;
  logic             prod_fire;
  logic             sum_fire;

  assign prod_fire = bus.prod_valid & prod_ready_q;
  assign sum_fire  = bus.sum_ready & sum_valid_q;

  // First term of a sum loads directly; later terms add with clamp.
  always_comb begin
    wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bus.prod_data);
    if (state_q == IDLE) begin
      acc_d = ACC_W'(bus.prod_data);
      ovf_d = 1'b0;
      cnt_d = CNT_W'(1);
      if (cfg_len == '0) begin
        len_d = CNT_W'(2**LEN_W);
      end else begin
        len_d = CNT_W'(cfg_len);
      end
    end else begin
      acc_d = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
      ovf_d = ovf_q | wide[ACC_W];
      cnt_d = cnt_q + CNT_W'(1);
      len_d = len_q;
    end
    last = (cnt_d == len_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b1;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= '0;
      sum_ovf_q    <= 1'b0;
      if (!rst_n) begin
        sum_cnt_q <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (prod_fire) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            if (last) begin
              state_q      <= DONE;
              prod_ready_q <= 1'b0;
              sum_valid_q  <= 1'b1;
              sum_data_q   <= acc_d;
              sum_ovf_q    <= ovf_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (sum_fire) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b1;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= '0;
            sum_ovf_q    <= 1'b0;
            sum_cnt_q    <= sum_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q      <= IDLE;
          prod_ready_q <= 1'b1;
          sum_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.sum_data   = sum_data_q;
  assign bus.sum_ovf    = sum_ovf_q;
  assign bus.sum_cnt    = sum_cnt_q;

endmodule
